// File: rtl/cp0_hazard_ctrl.sv
// CP0 read-after-write hazard controller: stalls an ID mfc0/eret until the youngest matching
// mtc0 retires. Define CP0_FWD_EN to forward last-stage mtc0 data instead of stalling for it.
module cp0_hazard_ctrl #(
  parameter int unsigned STAGES  = 3,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned EPC_REG = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OP_W-1:0]         id_cp0op,
  input  logic [REG_W-1:0]        id_cs,
  input  logic [SEL_W-1:0]        id_sel,
  input  logic [STAGES*OP_W-1:0]  st_cp0op,
  input  logic [STAGES*REG_W-1:0] st_cs,
  input  logic [STAGES*SEL_W-1:0] st_sel,
  input  logic [DATA_W-1:0]       wr_cp0data,
  input  logic                    stall_in,
  input  logic                    flush,
  output logic                    stall,
  output logic                    bubble,
  output logic [2:0]              hz_stage,
  output logic                    fwd_valid,
  output logic [DATA_W-1:0]       fwd_data
);

  localparam int unsigned CNT_W = $clog2(STAGES + 1);

  localparam logic [OP_W-1:0] OP_MTC0 = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MFC0 = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ERET = OP_W'(4);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       hz_q, hz_d;

  logic             rd_en;
  logic [REG_W-1:0] rd_cs;
  logic [SEL_W-1:0] rd_sel;
  logic             match;
  int unsigned      hit_k;
  int unsigned      need;

  always_comb begin
    rd_en  = 1'b0;
    rd_cs  = id_cs;
    rd_sel = id_sel;
    if (id_cp0op == OP_MFC0) begin
      rd_en = 1'b1;
    end else if (id_cp0op == OP_ERET) begin
      rd_en  = 1'b1;
      rd_cs  = REG_W'(EPC_REG);
      rd_sel = '0;
    end
  end

  // Scan oldest to youngest so the youngest (smallest k) match is the one kept.
  always_comb begin
    match = 1'b0;
    hit_k = 0;
    for (int k = int'(STAGES); k >= 1; k--) begin
      if (rd_en &&
          st_cp0op[(k-1)*int'(OP_W) +: OP_W] == OP_MTC0 &&
          st_cs[(k-1)*int'(REG_W) +: REG_W] == rd_cs &&
          st_sel[(k-1)*int'(SEL_W) +: SEL_W] == rd_sel) begin
        match = 1'b1;
        hit_k = k;
      end
    end
  end

`ifdef CP0_FWD_EN
  // The last-stage write is covered by forwarding, so one cycle less is needed.
  assign need      = STAGES - hit_k;
  assign fwd_valid = (state_q == IDLE) && match && (need == 0);
  assign fwd_data  = fwd_valid ? wr_cp0data : '0;
`else
  logic unused_data;
  assign need        = STAGES - hit_k + 1;
  assign fwd_valid   = 1'b0;
  assign fwd_data    = '0;
  assign unused_data = ^wr_cp0data;
`endif

  always_comb begin
    stall    = 1'b0;
    hz_stage = 3'd0;
    if (state_q == STALL) begin
      stall    = !flush;
      hz_stage = hz_q;
    end else begin
      stall = match && (need != 0) && !flush;
      if (stall && need == 1) begin
        hz_stage = 3'(hit_k);
      end
    end
  end

  assign bubble = stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hz_d    = hz_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      hz_d    = 3'd0;
    end else if (state_q == IDLE) begin
      if (match && !stall_in && need > 1) begin
        state_d = STALL;
        cnt_d   = CNT_W'(need - 1);
        hz_d    = 3'(hit_k);
      end
    end else if (!stall_in) begin
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        hz_d    = 3'd0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hz_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hz_q    <= hz_d;
    end
  end

endmodule

// File: tb/tb_cp0_hazard_ctrl.sv
// Table-driven bench for cp0_hazard_ctrl (STAGES=3); expectations follow CP0_FWD_EN when defined.
module tb_cp0_hazard_ctrl;

`ifdef CP0_FWD_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif

  localparam logic [2:0] MTC0 = 3'd2;
  localparam logic [2:0] MFC0 = 3'd3;
  localparam logic [2:0] ERET = 3'd4;
  localparam logic [2:0] NONE = 3'd0;
  localparam logic [31:0] D   = 32'hBFC0_0380;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] cs;
    logic [2:0] sel;
  } st_t;

  typedef struct {
    string       nm;
    logic [2:0]  iop;
    logic [4:0]  ics;
    logic [2:0]  isel;
    st_t         s1, s2, s3;
    logic [31:0] d;
    logic        sin;
    logic        fl;
    logic        es;
    logic [2:0]  ehz;
    logic        ehzc;
    logic        efv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  id_cp0op = '0;
  logic [4:0]  id_cs = '0;
  logic [2:0]  id_sel = '0;
  logic [8:0]  st_cp0op = '0;
  logic [14:0] st_cs = '0;
  logic [8:0]  st_sel = '0;
  logic [31:0] wr_cp0data = '0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;
  logic        stall, bubble, fwd_valid;
  logic [2:0]  hz_stage;
  logic [31:0] fwd_data;

  int   n_pass = 0;
  int   n_total = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  cp0_hazard_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_cp0op   (id_cp0op),
    .id_cs      (id_cs),
    .id_sel     (id_sel),
    .st_cp0op   (st_cp0op),
    .st_cs      (st_cs),
    .st_sel     (st_sel),
    .wr_cp0data (wr_cp0data),
    .stall_in   (stall_in),
    .flush      (flush),
    .stall      (stall),
    .bubble     (bubble),
    .hz_stage   (hz_stage),
    .fwd_valid  (fwd_valid),
    .fwd_data   (fwd_data)
  );

  always #5 clk = ~clk;

  function automatic st_t w(input int cs, input int sel);
    st_t s;
    s.op  = MTC0;
    s.cs  = 5'(cs);
    s.sel = 3'(sel);
    return s;
  endfunction

  function automatic st_t nop();
    return st_t'(0);
  endfunction

  task automatic row(input string nm, input logic [2:0] iop, input int ics, input int isel,
                     input st_t s1, input st_t s2, input st_t s3, input logic [31:0] d,
                     input logic sin, input logic fl, input logic es, input int ehz,
                     input logic ehzc, input logic efv);
    vec_t v;
    v.nm = nm; v.iop = iop; v.ics = 5'(ics); v.isel = 3'(isel);
    v.s1 = s1; v.s2 = s2; v.s3 = s3; v.d = d; v.sin = sin; v.fl = fl;
    v.es = es; v.ehz = 3'(ehz); v.ehzc = ehzc; v.efv = efv;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    id_cp0op   = v.iop;
    id_cs      = v.ics;
    id_sel     = v.isel;
    st_cp0op   = {v.s3.op, v.s2.op, v.s1.op};
    st_cs      = {v.s3.cs, v.s2.cs, v.s1.cs};
    st_sel     = {v.s3.sel, v.s2.sel, v.s1.sel};
    wr_cp0data = v.d;
    stall_in   = v.sin;
    flush      = v.fl;
    exp_q.push_back(v);
  endtask

  task automatic chk(input string nm, input string what, input logic [31:0] act,
                     input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s.%s: got %h, expected %h", nm, what, act, want);
  endtask

  task automatic check_one();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = exp_q.pop_front();
    chk(e.nm, "stall", 32'(stall), 32'(e.es));
    chk(e.nm, "bubble", 32'(bubble), 32'(e.es));
    if (e.ehzc) chk(e.nm, "hz_stage", 32'(hz_stage), 32'(e.ehz));
    chk(e.nm, "fwd_valid", 32'(fwd_valid), 32'(e.efv));
    chk(e.nm, "fwd_data", fwd_data, e.efv ? e.d : 32'h0);
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1 apply(v);
    @(negedge clk);
    check_one();
  endtask

  initial begin
    vec_t v;
    // Reset state, with non-matching inputs and live write data.
    row("reset", NONE, 0, 0, nop(), nop(), nop(), D, 0, 0, 0, 0, 1, 0);
    // EX writer advancing through the pipe.
    row("t1_c0", MFC0, 14, 0, w(14, 0), nop(), nop(), D, 0, 0, 1, 0, 0, 0);
    row("t1_c1", MFC0, 14, 0, nop(), w(14, 0), nop(), D, 0, 0, 1, 1, 1, 0);
    row("t1_c2", MFC0, 14, 0, nop(), nop(), w(14, 0), D, 0, 0, !F, F ? 0 : 1, 1, F);
    row("t1_c3", MFC0, 14, 0, nop(), nop(), nop(), D, 0, 0, 0, 0, 1, 0);
    // Youngest of two writers wins.
    row("t2_c0", MFC0, 12, 0, nop(), w(12, 0), w(12, 0), D, 0, 0, 1, 2, F, 0);
    row("t2_c1", MFC0, 12, 0, nop(), nop(), w(12, 0), D, 0, 0, !F, F ? 0 : 2, 1, F);
    row("t2_c2", MFC0, 12, 0, nop(), nop(), nop(), D, 0, 0, 0, 0, 1, 0);
    // Last-stage writer only.
    row("wr_c0", MFC0, 13, 2, nop(), nop(), w(13, 2), D, 0, 0, !F, F ? 0 : 3, 1, F);
    row("wr_c1", MFC0, 13, 2, nop(), nop(), nop(), D, 0, 0, 0, 0, 1, 0);
    // eret reads EPC sel 0 regardless of id_cs/id_sel.
    row("t3_sel1", ERET, 5, 3, w(14, 1), nop(), nop(), D, 0, 0, 0, 0, 1, 0);
    row("t3_c0", ERET, 5, 3, w(14, 0), nop(), nop(), D, 0, 0, 1, 0, 0, 0);
    row("t3_c1", ERET, 5, 3, nop(), w(14, 0), nop(), D, 0, 0, 1, 1, 1, 0);
    row("t3_c2", ERET, 5, 3, nop(), nop(), w(14, 0), D, 0, 0, !F, F ? 0 : 1, 1, F);
    row("t3_c3", ERET, 5, 3, nop(), nop(), nop(), D, 0, 0, 0, 0, 1, 0);
    // Non-readers and mismatching targets.
    row("mtc0_id", MTC0, 14, 0, w(14, 0), nop(), nop(), D, 0, 0, 0, 0, 1, 0);
    row("sel_miss", MFC0, 14, 1, w(14, 0), w(14, 2), w(15, 1), D, 0, 0, 0, 0, 1, 0);
    // stall_in in IDLE loads nothing; stall_in mid-STALL freezes the count.
    row("t4_idle", MFC0, 14, 0, w(14, 0), nop(), nop(), D, 1, 0, 1, 0, 0, 0);
    row("t4_c0", MFC0, 14, 0, w(14, 0), nop(), nop(), D, 0, 0, 1, 0, 0, 0);
    row("t4_c1", MFC0, 14, 0, nop(), w(14, 0), nop(), D, 1, 0, 1, 1, 1, 0);
    row("t4_c2", NONE, 0, 0, nop(), w(14, 0), nop(), D, 1, 0, 1, 1, 1, 0);
    row("t4_c3", MFC0, 14, 0, nop(), w(14, 0), nop(), D, 0, 0, 1, 1, 1, 0);
    row("t4_c4", MFC0, 14, 0, nop(), nop(), w(14, 0), D, 0, 0, !F, F ? 0 : 1, 1, F);
    row("t4_c5", MFC0, 14, 0, nop(), nop(), nop(), D, 0, 0, 0, 0, 1, 0);
    // Flush mid-stall returns to IDLE; flush in IDLE suppresses the stall and the load.
    row("t5_c0", MFC0, 14, 0, w(14, 0), nop(), nop(), D, 0, 0, 1, 0, 0, 0);
    row("t5_flush", MFC0, 14, 0, nop(), w(14, 0), nop(), D, 1, 1, 0, 0, 0, 0);
    row("t5_idle", MFC0, 14, 0, nop(), nop(), w(14, 0), D, 0, 0, !F, F ? 0 : 3, 1, F);
    row("t5_c3", MFC0, 14, 0, nop(), nop(), nop(), D, 0, 0, 0, 0, 1, 0);
    row("fl_idle", MFC0, 14, 0, w(14, 0), nop(), nop(), D, 0, 1, 0, 0, 1, 0);
    row("fl_after", MFC0, 14, 0, nop(), nop(), nop(), D, 0, 0, 0, 0, 1, 0);

    // Reset row is checked while rst_n is still low.
    apply(tbl[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_one();
    rst_n = 1'b1;
    for (int i = 1; i < tbl.size(); i++) step(tbl[i]);

    // Asynchronous reset in the middle of a stall.
    v = tbl[1];
    v.nm = "rst_c0";
    step(v);
    v = tbl[2];
    v.nm = "rst_c1";
    v.iop = NONE;
    step(v);
    #2 rst_n = 1'b0;
    v.nm = "rst_async";
    v.es = 1'b0; v.ehz = 3'd0; v.ehzc = 1'b1;
    #1 apply(v);
    #1 check_one();
    @(negedge clk);
    rst_n = 1'b1;
    v = tbl[4];
    v.nm = "rst_after";
    step(v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
